// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the multi-cycle CPU.
// It sits between the instruction register and the datapath. It sequences each
// instruction through IF/ID/EXE/MEM/WB states. It drives the ALU control (aluop,
// alusrca, alusrcb) and the datapath enables. It resolves branches using the ALU
// zero/sign flags.
// Outputs are combinational from the registered state plus the current opcode.
// All write/strobe enables are forced low while rst_n is low.
// Optional build macro: MCU_DBG_EN adds the debug ports state[2:0] and illegal_op.
// It also adds an assertion that mrd and mwr are never high together.
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                sign,
  output logic                pcwre,
  output logic                irwre,
  output logic                alusrca,
  output logic                alusrcb,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                extsel,
  output logic [1:0]          regdst,
  output logic                regwre,
  output logic                wrregdsrc,
  output logic                dbdatasrc,
  output logic                mrd,
  output logic                mwr,
  output logic [1:0]          pcsrc
`ifdef MCU_DBG_EN
  ,
  output logic [2:0]          state,
  output logic                illegal_op
`endif
);

  // Opcode map
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_ADDIU = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(6'b010000);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b010001);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b010010);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(6'b010011);
  localparam logic [OPCODE_W-1:0] OP_XNOR  = OPCODE_W'(6'b010100);
  localparam logic [OPCODE_W-1:0] OP_SLL   = OPCODE_W'(6'b011000);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b011100);
  localparam logic [OPCODE_W-1:0] OP_SLTIU = OPCODE_W'(6'b011101);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b100110);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100111);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b110000);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b110001);
  localparam logic [OPCODE_W-1:0] OP_BLTZ  = OPCODE_W'(6'b110010);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b111000);
  localparam logic [OPCODE_W-1:0] OP_JR    = OPCODE_W'(6'b111001);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b111010);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(6'b111111);

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_XNOR = ALUOP_W'(3'b111);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t cur_state;

  logic is_rtype, is_imm_b, is_zext, is_sll;
  logic is_branch, is_lw, is_sw, is_j, is_jr, is_jal, is_halt, is_illegal;
  logic [ALUOP_W-1:0] alu_sel;
  logic br_taken;
  logic pcwre_raw, irwre_raw, regwre_raw, mrd_raw, mwr_raw;

  // Opcode decode into instruction classes and the ALU operation.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    is_rtype   = 1'b0;
    is_imm_b   = 1'b0;
    is_zext    = 1'b0;
    is_sll     = 1'b0;
    is_branch  = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_j       = 1'b0;
    is_jr      = 1'b0;
    is_jal     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_sel    = ALU_ADD;
    case (opcode)
      OP_ADD:   begin is_rtype = 1'b1; alu_sel = ALU_ADD;  end
      OP_SUB:   begin is_rtype = 1'b1; alu_sel = ALU_SUB;  end
      OP_ADDIU: begin is_imm_b = 1'b1; alu_sel = ALU_ADD;  end
      OP_AND:   begin is_rtype = 1'b1; alu_sel = ALU_AND;  end
      OP_ANDI:  begin is_imm_b = 1'b1; is_zext = 1'b1; alu_sel = ALU_AND; end
      OP_ORI:   begin is_imm_b = 1'b1; is_zext = 1'b1; alu_sel = ALU_OR;  end
      OP_OR:    begin is_rtype = 1'b1; alu_sel = ALU_OR;   end
      OP_XNOR:  begin is_rtype = 1'b1; alu_sel = ALU_XNOR; end
      OP_SLL:   begin is_rtype = 1'b1; is_sll = 1'b1; alu_sel = ALU_SLL; end
      OP_SLTI:  begin is_imm_b = 1'b1; alu_sel = ALU_SLT;  end
      OP_SLTIU: begin is_imm_b = 1'b1; alu_sel = ALU_SLTU; end
      OP_SW:    begin is_imm_b = 1'b1; is_sw = 1'b1; alu_sel = ALU_ADD; end
      OP_LW:    begin is_imm_b = 1'b1; is_lw = 1'b1; alu_sel = ALU_ADD; end
      OP_BEQ, OP_BNE, OP_BLTZ: begin is_branch = 1'b1; alu_sel = ALU_SUB; end
      OP_J:     is_j    = 1'b1;
      OP_JR:    is_jr   = 1'b1;
      OP_JAL:   is_jal  = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

  // Branch condition evaluated from the ALU flags of the rs-rt subtraction.
  always_comb begin
    br_taken = ((opcode == OP_BEQ)  &&  zero) ||
               ((opcode == OP_BNE)  && !zero) ||
               ((opcode == OP_BLTZ) &&  sign && !zero);
  end

  // State register with next-state selection; async reset aborts any instruction.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IF;
    end else begin
      case (cur_state)
        S_IF: cur_state <= S_ID;
        S_ID: begin
          if (is_j || is_jr || is_jal || is_illegal) cur_state <= S_IF;
          else if (is_halt)                          cur_state <= S_ID;
          else if (is_branch)                        cur_state <= S_EXE_BR;
          else if (is_lw || is_sw)                   cur_state <= S_EXE_LS;
          else                                       cur_state <= S_EXE_AL;
        end
        S_EXE_AL: cur_state <= S_WB_AL;
        S_WB_AL:  cur_state <= S_IF;
        S_EXE_BR: cur_state <= S_IF;
        S_EXE_LS: cur_state <= S_MEM;
        S_MEM:    cur_state <= is_lw ? S_WB_LD : S_IF;
        S_WB_LD:  cur_state <= S_IF;
        default:  cur_state <= S_IF;
      endcase
    end
  end

  // Mux selects come straight from the opcode; they are harmless outside the states that use them.
  always_comb begin
    alusrca   = is_sll;
    alusrcb   = is_imm_b;
    extsel    = ~is_zext;
    dbdatasrc = is_lw;
    wrregdsrc = ~is_jal;
    if (is_jal)        regdst = 2'b00;
    else if (is_rtype) regdst = 2'b10;
    else               regdst = 2'b01;
  end

  // State-dependent enables, ALU op and PC source.
  always_comb begin
    pcwre_raw  = 1'b0;
    irwre_raw  = 1'b0;
    regwre_raw = 1'b0;
    mrd_raw    = 1'b0;
    mwr_raw    = 1'b0;
    aluop      = ALU_ADD;
    pcsrc      = 2'b00;
    case (cur_state)
      S_IF: irwre_raw = 1'b1;
      S_ID: begin
        pcwre_raw  = is_j || is_jr || is_jal || is_illegal;
        regwre_raw = is_jal;
        if (is_j || is_jal) pcsrc = 2'b11;
        else if (is_jr)     pcsrc = 2'b10;
      end
      S_EXE_AL: aluop = alu_sel;
      S_EXE_LS: aluop = alu_sel;
      S_EXE_BR: begin
        aluop     = alu_sel;
        pcwre_raw = 1'b1;
        pcsrc     = br_taken ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        mrd_raw   = is_lw;
        mwr_raw   = is_sw;
        pcwre_raw = is_sw;
      end
      S_WB_AL, S_WB_LD: begin
        regwre_raw = 1'b1;
        pcwre_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every write/strobe enable immediately, independent of the clock.
  always_comb begin
    pcwre  = pcwre_raw  & rst_n;
    irwre  = irwre_raw  & rst_n;
    regwre = regwre_raw & rst_n;
    mrd    = mrd_raw    & rst_n;
    mwr    = mwr_raw    & rst_n;
  end

`ifdef MCU_DBG_EN
  // Debug visibility of the FSM and the illegal-opcode detection.
  always_comb begin
    state      = cur_state;
    illegal_op = (cur_state == S_ID) && is_illegal;
  end

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n) !(mrd && mwr));
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Each instruction pushes its expected per-cycle output vectors to a queue when
// its opcode is driven. Every cycle pops one entry and compares it against the DUT.
module tb_multicycle_control_unit;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
  localparam logic [5:0] AND_ = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] OR_ = 6'b010011, XNOR_ = 6'b010100, SLL = 6'b011000;
  localparam logic [5:0] SLTI = 6'b011100, SLTIU = 6'b011101, SW = 6'b100110;
  localparam logic [5:0] LW = 6'b100111, BEQ = 6'b110000, BNE = 6'b110001;
  localparam logic [5:0] BLTZ = 6'b110010, J = 6'b111000, JR = 6'b111001;
  localparam logic [5:0] JAL = 6'b111010, HALT = 6'b111111;

  typedef enum {P_IF, P_ID, P_EXE, P_MEM, P_WB, P_RST} phase_t;

  logic       clk, rst_n, zero, sign;
  logic [5:0] opcode;
  logic       pcwre, irwre, alusrca, alusrcb, extsel, regwre, wrregdsrc, dbdatasrc, mrd, mwr;
  logic [2:0] aluop;
  logic [1:0] regdst, pcsrc;
`ifdef MCU_DBG_EN
  logic [2:0] dbg_state;
  logic       dbg_illegal;
`endif

  multicycle_control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .sign      (sign),
    .pcwre     (pcwre),
    .irwre     (irwre),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .extsel    (extsel),
    .regdst    (regdst),
    .regwre    (regwre),
    .wrregdsrc (wrregdsrc),
    .dbdatasrc (dbdatasrc),
    .mrd       (mrd),
    .mwr       (mwr),
    .pcsrc     (pcsrc)
`ifdef MCU_DBG_EN
    ,
    .state     (dbg_state),
    .illegal_op(dbg_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] dut_vec;
  assign dut_vec = {pcwre, irwre, alusrca, alusrcb, aluop, extsel, regdst,
                    regwre, wrregdsrc, dbdatasrc, mrd, mwr, pcsrc};

  logic [16:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_alu_instr(input logic [5:0] op);
    return op inside {ADD, SUB, ADDIU, AND_, ANDI, ORI, OR_, XNOR_, SLL, SLTI, SLTIU};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_alu_instr(op) || (op inside {SW, LW, BEQ, BNE, BLTZ, J, JR, JAL, HALT});
  endfunction

  // Reference output vector for one phase of an instruction, derived from the opcode table.
  function automatic logic [16:0] exp_bits(input logic [5:0] op, input phase_t ph,
                                           input logic z, input logic s);
    logic [2:0] alu;
    logic [1:0] dst, psrc;
    logic a_src, b_src, ext, wsrc, dbsrc, pw, iw, rw, rd, wr, br, taken;
    case (op)
      SUB, BEQ, BNE, BLTZ: alu = 3'b001;
      SLL:                 alu = 3'b010;
      OR_, ORI:            alu = 3'b011;
      AND_, ANDI:          alu = 3'b100;
      SLTIU:               alu = 3'b101;
      SLTI:                alu = 3'b110;
      XNOR_:               alu = 3'b111;
      default:             alu = 3'b000;
    endcase
    a_src = (op == SLL);
    b_src = op inside {ADDIU, ANDI, ORI, SLTI, SLTIU, SW, LW};
    ext   = !(op inside {ANDI, ORI});
    if (op == JAL)                                   dst = 2'b00;
    else if (op inside {ADD, SUB, AND_, OR_, XNOR_, SLL}) dst = 2'b10;
    else                                             dst = 2'b01;
    wsrc  = (op != JAL);
    dbsrc = (op == LW);
    br    = op inside {BEQ, BNE, BLTZ};
    taken = (op == BEQ && z) || (op == BNE && !z) || (op == BLTZ && s && !z);
    iw = (ph == P_IF);
    pw = (ph == P_ID && ((op inside {J, JR, JAL}) || !is_legal(op))) ||
         (ph == P_EXE && br) || (ph == P_WB) || (ph == P_MEM && op == SW);
    rw = (ph == P_WB) || (ph == P_ID && op == JAL);
    rd = (ph == P_MEM && op == LW);
    wr = (ph == P_MEM && op == SW);
    psrc = 2'b00;
    if (ph == P_ID && (op == J || op == JAL)) psrc = 2'b11;
    else if (ph == P_ID && op == JR)          psrc = 2'b10;
    else if (ph == P_EXE && br && taken)      psrc = 2'b01;
    if (ph != P_EXE) alu = 3'b000;
    return {pw, iw, a_src, b_src, alu, ext, dst, rw, wsrc, dbsrc, rd, wr, psrc};
  endfunction

  task automatic push(input logic [5:0] op, input phase_t ph, input logic z, input logic s);
    exp_q.push_back(exp_bits(op, ph, z, s));
    tag_q.push_back($sformatf("op%b_%s", op, ph.name()));
  endtask

  // Compare n queued expectations, one per cycle; each starts just after a falling edge.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        check(tag_q.pop_front(), 32'(dut_vec), 32'(exp_q.pop_front()));
      end
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
    opcode = op;
    zero   = z;
    sign   = s;
    push(op, P_IF, z, s);
    push(op, P_ID, z, s);
    if (is_alu_instr(op)) begin
      push(op, P_EXE, z, s);
      push(op, P_WB, z, s);
    end else if (op == LW) begin
      push(op, P_EXE, z, s);
      push(op, P_MEM, z, s);
      push(op, P_WB, z, s);
    end else if (op == SW) begin
      push(op, P_EXE, z, s);
      push(op, P_MEM, z, s);
    end else if (op inside {BEQ, BNE, BLTZ}) begin
      push(op, P_EXE, z, s);
    end
    drain(exp_q.size());
  endtask

  logic [5:0] seq[$] = '{ADD, SUB, ADDIU, AND_, ANDI, ORI, OR_, XNOR_, SLL, SLTI, SLTIU,
                         LW, SW, J, JR, JAL, 6'b000011, 6'b101010, ADD};

  initial begin
    rst_n  = 1'b0;
    opcode = ADD;
    zero   = 1'b0;
    sign   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec), 32'(exp_bits(ADD, P_RST, 1'b0, 1'b0)));
    check("reset_irwre", 32'(irwre), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (seq[i]) run_instr(seq[i], 1'b0, 1'b0);

    // Branch resolution, including the bltz corner with zero and sign both set.
    run_instr(BEQ,  1'b1, 1'b0);
    run_instr(BEQ,  1'b0, 1'b0);
    run_instr(BNE,  1'b0, 1'b1);
    run_instr(BNE,  1'b1, 1'b0);
    run_instr(BLTZ, 1'b1, 1'b1);
    run_instr(BLTZ, 1'b0, 1'b1);
    run_instr(BLTZ, 1'b0, 1'b0);

    // Halt parks in ID; only reset leaves it.
    opcode = HALT;
    push(HALT, P_IF, 1'b0, 1'b0);
    repeat (11) push(HALT, P_ID, 1'b0, 1'b0);
    drain(exp_q.size());
    rst_n = 1'b0;
    #1;
    check("halt_reset", 32'(dut_vec), 32'(exp_bits(HALT, P_RST, 1'b0, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(ADD, 1'b0, 1'b0);

    // Reset asserted in MEM of sw drops the write strobe at once.
    opcode = SW;
    push(SW, P_IF, 1'b0, 1'b0);
    push(SW, P_ID, 1'b0, 1'b0);
    push(SW, P_EXE, 1'b0, 1'b0);
    push(SW, P_MEM, 1'b0, 1'b0);
    drain(3);
    #1;
    check(tag_q.pop_front(), 32'(dut_vec), 32'(exp_q.pop_front()));
    check("sw_mem_mwr", 32'(mwr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("sw_abort_mwr", 32'(mwr), 32'd0);
    check("sw_abort_vec", 32'(dut_vec), 32'(exp_bits(SW, P_RST, 1'b0, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(LW, 1'b0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
